tmac_uni_sched: RTL and testbench

Sequencer for the unipolar temporal-coded multiplier lane in the MAC16 datapath. Accepts a stream of 8-bit operand pairs over a valid/ready handshake and loads them one at a time into the multiplier (A as temporal length, B as unipolar magnitude). It waits for each temporal window to finish, counts the multiplier's output ones into a dot-product accumulator, and presents the sum after TERMS pairs over a second valid/ready handshake.

---
 rtl/tmac_uni_sched.sv | 157 +++++++++++++++
 tb/tb_tmac_uni_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmac_uni_sched.sv
`default_nettype none
// ============================================================================
// Module   : tmac_uni_sched
// Purpose  : Sequencer for the unipolar temporal-coded multiplier lane.
//            Accepts operand pairs one at a time, loads them into the
//            multiplier, counts the multiplier's output ones for the whole
//            temporal window and presents the dot-product sum after TERMS
//            pairs.
// Ports    : clk, rst (async, active-high), abort (sync, highest priority)
//            in_valid/in_ready/in_a/in_b   operand pair handshake
//            mul_a/mul_b/mul_load_a/mul_load_b  multiplier load interface
//            mul_oc/mul_stop               multiplier output bit / stop flag
//            acc_out/acc_valid/acc_ready   dot-product result handshake
//            busy                          high whenever not in IDLE
// Revision : 1.0  initial release
// ============================================================================
module tmac_uni_sched #(
    parameter int TERMS = 16,
    parameter int WIDTH = 8,
    parameter int ACCW  = WIDTH + $clog2(TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_load_a,
    output logic             mul_load_b,
    input  logic             mul_oc,
    input  logic             mul_stop,
    output logic [ACCW-1:0]  acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy
);

    // A single-term batch still needs a one-bit counter.
    localparam int CNTW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNTW-1:0] LAST_TERM = CNTW'(TERMS - 1);
    localparam logic [ACCW-1:0] ACC_MAX   = {ACCW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t            state;
    logic [ACCW-1:0]   acc;
    logic [CNTW-1:0]   term_cnt;

    // The accumulator is the result register; it is only qualified by
    // acc_valid, so it can drive the output directly.
    assign acc_out = acc;

    // All handshake and strobe outputs are registered and updated together
    // with the state transition that makes them true.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            term_cnt   <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_load_a <= 1'b0;
            mul_load_b <= 1'b0;
            acc_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else if (abort) begin
            // The multiplier may be left mid-window; the next load
            // overwrites its buffers, so it needs no cleanup here.
            state      <= S_IDLE;
            acc        <= '0;
            term_cnt   <= '0;
            mul_load_a <= 1'b0;
            mul_load_b <= 1'b0;
            acc_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_a      <= in_a;
                        mul_b      <= in_b;
                        // The first pair of a batch discards the previous
                        // batch's result, which was held until now.
                        if (term_cnt == '0) begin
                            acc <= '0;
                        end
                        mul_load_a <= 1'b1;
                        mul_load_b <= 1'b1;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    mul_load_a <= 1'b0;
                    mul_load_b <= 1'b0;
                    state      <= S_ARM;
                end

                S_ARM: begin
                    // The multiplier's stop flag is still high from the load
                    // in this cycle, so it is deliberately not looked at.
                    state <= S_RUN;
                end

                S_RUN: begin
                    if (!mul_stop) begin
                        if (mul_oc && (acc != ACC_MAX)) begin
                            acc <= acc + ACCW'(1);
                        end
                    end else if (term_cnt == LAST_TERM) begin
                        term_cnt  <= '0;
                        acc_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        term_cnt <= term_cnt + CNTW'(1);
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                S_OUT: begin
                    if (acc_ready) begin
                        acc_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    mul_load_a <= 1'b0;
                    mul_load_b <= 1'b0;
                    acc_valid  <= 1'b0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmac_uni_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmac_uni_sched
// Purpose  : Self-checking bench for tmac_uni_sched. A behavioural temporal
//            multiplier drives mul_oc/mul_stop; expected dot products are
//            computed arithmetically and queued, and a monitor compares them
//            at every result handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_tmac_uni_sched;

    localparam int TERMS = 16;
    localparam int WIDTH = 8;
    localparam int ACCW  = WIDTH + $clog2(TERMS);

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_load_a;
    logic             mul_load_b;
    logic             mul_oc;
    logic             mul_stop;
    logic [ACCW-1:0]  acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             busy;

    tmac_uni_sched #(.TERMS(TERMS), .WIDTH(WIDTH), .ACCW(ACCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_load_a (mul_load_a),
        .mul_load_b (mul_load_b),
        .mul_oc     (mul_oc),
        .mul_stop   (mul_stop),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int run_sum = 0;
    int term_idx = 0;
    bit force_ones = 1'b0;   // multiplier emits ~stop instead of a B-density stream
    bit hold_ready = 1'b0;   // consumer refrains from accepting the result

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural temporal multiplier: stop stays high through the load and
    // the following cycle, then stays low for A cycles. In those A steps the
    // ones are spread evenly so that exactly floor(A*B/256) are emitted.
    // While stopped the output bit carries random noise to be ignored.
    // ------------------------------------------------------------------
    logic [8:0] m_cnt;
    logic       m_pend;
    logic [7:0] m_len;
    logic [7:0] m_mag;
    logic       m_noise;
    int         m_i;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= '0;
            m_pend  <= 1'b0;
            m_len   <= '0;
            m_mag   <= '0;
            m_noise <= 1'b0;
        end else begin
            m_noise <= 1'($urandom);
            if (mul_load_a && mul_load_b) begin
                m_pend <= 1'b1;
                m_cnt  <= '0;
                m_len  <= mul_a;
                m_mag  <= mul_b;
            end else if (m_pend) begin
                m_pend <= 1'b0;
                m_cnt  <= {1'b0, m_len};
            end else if (m_cnt != '0) begin
                m_cnt <= m_cnt - 9'd1;
            end
        end
    end

    assign mul_stop = (m_cnt == '0);

    always_comb begin
        m_i    = int'(m_len) - int'(m_cnt);
        mul_oc = 1'b0;
        if (mul_stop) begin
            mul_oc = force_ones ? 1'b0 : m_noise;
        end else if (force_ones) begin
            mul_oc = 1'b1;
        end else begin
            mul_oc = ((((m_i + 1) * int'(m_mag)) / 256) - ((m_i * int'(m_mag)) / 256)) != 0;
        end
    end

    // ------------------------------------------------------------------
    // Result consumer: random 0..5 cycle delay before accepting.
    // ------------------------------------------------------------------
    initial begin
        acc_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_valid && !hold_ready && !rst) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
                acc_ready = 1'b1;
                @(posedge clk);
                #1;
                acc_ready = 1'b0;
            end
        end
    end

    // Monitor: every result handshake pops one expected sum.
    int exp_v;
    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_v = exp_q.pop_front();
                check("acc_out", int'(acc_out), exp_v);
            end
        end
    end

    // ------------------------------------------------------------------
    // Send one pair and follow it until the DUT returns to IDLE or raises
    // acc_valid. disturb: 0 none, 1 abort, 2 reset, applied `at` cycles
    // after the accept edge.
    // ------------------------------------------------------------------
    task automatic send(input int a, input int b, input int disturb, input int at);
        int n;
        int loads;
        int done_k;
        in_a     = 8'(a);
        in_b     = 8'(b);
        n        = 0;
        in_valid = 1'($urandom_range(0, 1));
        while (!(in_valid && in_ready)) begin
            if (n > 2000) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            n++;
            in_valid = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        loads    = 0;
        done_k   = -1;
        for (int k = 0; k < 600; k++) begin
            if (disturb != 0 && k == at) begin
                check("in_ready_while_busy", int'(in_ready), 0);
                if (disturb == 1) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                    check("abort_busy", int'(busy), 0);
                    check("abort_in_ready", int'(in_ready), 1);
                    check("abort_acc_valid", int'(acc_valid), 0);
                    check("abort_acc", int'(acc_out), 0);
                end else begin
                    rst = 1'b1;
                    #1;
                    check("rst_busy", int'(busy), 0);
                    check("rst_acc_valid", int'(acc_valid), 0);
                    check("rst_load_a", int'(mul_load_a), 0);
                    check("rst_load_b", int'(mul_load_b), 0);
                    check("rst_in_ready", int'(in_ready), 1);
                    check("rst_acc", int'(acc_out), 0);
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                end
                run_sum  = 0;
                term_idx = 0;
                return;
            end
            if (mul_load_a && mul_load_b) begin
                loads += (k == 0) ? 1 : 100;
            end
            if (in_ready || acc_valid) begin
                done_k = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("load_pulse", loads, 1);
        check("term_cycles", done_k, a + 3);
        run_sum += force_ones ? a : (a * b) / 256;
        term_idx++;
        if (term_idx == TERMS) begin
            exp_q.push_back(run_sum);
            run_sum  = 0;
            term_idx = 0;
        end
    endtask

    task automatic random_batch(input int amax);
        for (int t = 0; t < TERMS; t++) begin
            send($urandom_range(0, amax), $urandom_range(0, 255), 0, 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_acc_valid", int'(acc_valid), 0);
        check("reset_load", int'(mul_load_a | mul_load_b), 0);
        check("reset_acc", int'(acc_out), 0);
        check("reset_mul_a", int'(mul_a), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a RUN window, then a fresh batch.
        force_ones = 1'b1;
        send(7, 255, 0, 0);
        send(9, 100, 0, 0);
        send(50, 255, 2, 8);
        send(10, 255, 0, 0);   // single-term timing: 10 + 3 cycles, 1 load cycle
        send(0, 200, 0, 0);    // zero length: one RUN cycle only
        send(5, 255, 0, 0);
        for (int t = 3; t < TERMS - 1; t++) begin
            send($urandom_range(0, 12), 255, 0, 0);
        end
        send(10, 255, 0, 0);   // acc_valid follows the terminating RUN cycle

        // Full batch of maximum operands with the result held back.
        hold_ready = 1'b1;
        for (int t = 0; t < TERMS; t++) begin
            send(255, 255, 0, 0);
        end
        check("hold_acc_valid", int'(acc_valid), 1);
        in_a     = 8'd1;
        in_b     = 8'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_acc_out", int'(acc_out), TERMS * 255);
            check("hold_valid_kept", int'(acc_valid), 1);
        end
        in_valid   = 1'b0;
        hold_ready = 1'b0;

        // Abort during the RUN window of term 7, then an independent batch.
        for (int t = 0; t < 7; t++) begin
            send($urandom_range(3, 20), 255, 0, 0);
        end
        send(40, 255, 1, 6);
        force_ones = 1'b0;
        random_batch(20);

        // Randomised traffic with backpressure on both sides.
        for (int bt = 0; bt < 200; bt++) begin
            force_ones = ($urandom_range(0, 7) == 0);
            random_batch(20);
        end

        begin
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 500) begin
                @(posedge clk);
                w++;
            end
            check("results_drained", exp_q.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
